// File: rtl/radix2_bfly_pipe_pkg.sv
// Shared constants for the radix-2 butterfly pipeline: mode encoding and stage count.
package bfly_pkg;
    localparam logic MODE_DIT = 1'b0;
    localparam logic MODE_DIF = 1'b1;
    localparam int   STAGES   = 4;
endpackage

// File: rtl/radix2_bfly_pipe_cmul.sv
// Rounded complex multiply p = a * w, where the twiddle is scaled by 2^(TW-1).
module bfly_cmul #(
    parameter int DW = 42,
    parameter int TW = 8
) (
    input  logic signed [DW-1:0]  a_r,
    input  logic signed [DW-1:0]  a_i,
    input  logic signed [TW-1:0]  w_r,
    input  logic signed [TW-1:0]  w_i,
    output logic signed [DW+TW:0] p_r,
    output logic signed [DW+TW:0] p_i
);
    localparam int PW = DW + TW + 1;
    localparam logic signed [PW-1:0] RND = PW'(1) << (TW-2);

    logic signed [PW-1:0] ar, ai, wr, wi, re, im;

    // PW bits hold the sum of two products plus the rounding bias without overflow.
    always_comb begin
        ar  = PW'(a_r);
        ai  = PW'(a_i);
        wr  = PW'(w_r);
        wi  = PW'(w_i);
        re  = ar * wr - ai * wi;
        im  = ar * wi + ai * wr;
        p_r = (re + RND) >>> (TW-1);
        p_i = (im + RND) >>> (TW-1);
    end
endmodule

// File: rtl/radix2_bfly_pipe.sv
// Radix-2 DIT/DIF butterfly, 4 registered stages sharing one stall (adv) signal.
// Define BFLY_SAT_EN to clamp results and report sat; without it results wrap modulo 2^DW.
module radix2_bfly_pipe
    import bfly_pkg::*;
#(
    parameter int DW = 41,
    parameter int TW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mode,
    input  logic                 scale,
    input  logic signed [DW-1:0] a_r,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [DW-1:0] b_r,
    input  logic signed [DW-1:0] b_i,
    input  logic signed [TW-1:0] w_r,
    input  logic signed [TW-1:0] w_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] x_r,
    output logic signed [DW-1:0] x_i,
    output logic signed [DW-1:0] y_r,
    output logic signed [DW-1:0] y_i,
    output logic                 sat
);
    localparam int IW = DW + TW + 2;
    localparam logic signed [IW-1:0] ONE = IW'(1);

    logic              adv;
    logic [STAGES:1]   vld;

    logic signed [DW-1:0] s1_a_r, s1_a_i, s1_b_r, s1_b_i;
    logic signed [TW-1:0] s1_w_r, s1_w_i;
    logic                 s1_mode, s1_scale;

    logic signed [DW-1:0] s2_a_r, s2_a_i, s2_b_r, s2_b_i;
    logic signed [DW:0]   s2_s_r, s2_s_i, s2_d_r, s2_d_i;
    logic signed [TW-1:0] s2_w_r, s2_w_i;
    logic                 s2_mode, s2_scale;

    logic signed [DW:0]   op_r, op_i;
    logic signed [IW-1:0] p_r, p_i;

    logic signed [DW-1:0] s3_a_r, s3_a_i;
    logic signed [DW:0]   s3_s_r, s3_s_i;
    logic signed [IW-1:0] s3_p_r, s3_p_i;
    logic                 s3_mode, s3_scale;

    logic signed [IW-1:0] res [4];
    logic signed [IW-1:0] v;
    logic signed [DW-1:0] q [4];
    logic [3:0]           ovf;

    assign out_valid = vld[STAGES];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    // DIT multiplies b, DIF multiplies the pre-added difference a-b.
    assign op_r = (s2_mode == MODE_DIF) ? s2_d_r : (DW+1)'(s2_b_r);
    assign op_i = (s2_mode == MODE_DIF) ? s2_d_i : (DW+1)'(s2_b_i);

    bfly_cmul #(.DW(DW+1), .TW(TW)) u_cmul (
        .a_r(op_r), .a_i(op_i), .w_r(s2_w_r), .w_i(s2_w_i), .p_r(p_r), .p_i(p_i)
    );

    always_comb begin
        v   = '0;
        ovf = '0;
        if (s3_mode == MODE_DIT) begin
            res[0] = IW'(s3_a_r) + s3_p_r;
            res[1] = IW'(s3_a_i) + s3_p_i;
            res[2] = IW'(s3_a_r) - s3_p_r;
            res[3] = IW'(s3_a_i) - s3_p_i;
        end else begin
            res[0] = IW'(s3_s_r);
            res[1] = IW'(s3_s_i);
            res[2] = s3_p_r;
            res[3] = s3_p_i;
        end
        for (int k = 0; k < 4; k++) begin
            v = s3_scale ? (res[k] + ONE) >>> 1 : res[k];
`ifdef BFLY_SAT_EN
            if (v > ((ONE <<< (DW-1)) - ONE)) begin
                v      = (ONE <<< (DW-1)) - ONE;
                ovf[k] = 1'b1;
            end else if (v < -(ONE <<< (DW-1))) begin
                v      = -(ONE <<< (DW-1));
                ovf[k] = 1'b1;
            end
`endif
            q[k] = v[DW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld <= '0;
            x_r <= '0;
            x_i <= '0;
            y_r <= '0;
            y_i <= '0;
            sat <= 1'b0;
        end else if (adv) begin
            vld <= {vld[STAGES-1:1], in_valid};
            x_r <= q[0];
            x_i <= q[1];
            y_r <= q[2];
            y_i <= q[3];
            sat <= |ovf;
        end
    end

    // Stage data needs no reset: a stage is only observed through its valid bit.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_a_r   <= a_r;
            s1_a_i   <= a_i;
            s1_b_r   <= b_r;
            s1_b_i   <= b_i;
            s1_w_r   <= w_r;
            s1_w_i   <= w_i;
            s1_mode  <= mode;
            s1_scale <= scale;

            s2_a_r   <= s1_a_r;
            s2_a_i   <= s1_a_i;
            s2_b_r   <= s1_b_r;
            s2_b_i   <= s1_b_i;
            s2_s_r   <= (DW+1)'(s1_a_r) + (DW+1)'(s1_b_r);
            s2_s_i   <= (DW+1)'(s1_a_i) + (DW+1)'(s1_b_i);
            s2_d_r   <= (DW+1)'(s1_a_r) - (DW+1)'(s1_b_r);
            s2_d_i   <= (DW+1)'(s1_a_i) - (DW+1)'(s1_b_i);
            s2_w_r   <= s1_w_r;
            s2_w_i   <= s1_w_i;
            s2_mode  <= s1_mode;
            s2_scale <= s1_scale;

            s3_a_r   <= s2_a_r;
            s3_a_i   <= s2_a_i;
            s3_s_r   <= s2_s_r;
            s3_s_i   <= s2_s_i;
            s3_p_r   <= p_r;
            s3_p_i   <= p_i;
            s3_mode  <= s2_mode;
            s3_scale <= s2_scale;
        end
    end
endmodule

// File: tb/tb_radix2_bfly_pipe.sv
// Scoreboard bench for radix2_bfly_pipe (DW=16, TW=8): directed vectors plus randomized beats vs a reference model.
`timescale 1ns/1ps
module tb_radix2_bfly_pipe;
    localparam int DW = 16;
    localparam int TW = 8;

    typedef struct {
        logic signed [DW-1:0] a_r, a_i, b_r, b_i;
        logic signed [TW-1:0] w_r, w_i;
        logic                 mode, scale;
    } beat_t;

    typedef struct {
        longint x_r, x_i, y_r, y_i;
        bit     sat;
        bit     lat;
        longint acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, mode, scale, out_valid, out_ready, sat;
    logic signed [DW-1:0] a_r, a_i, b_r, b_i, x_r, x_i, y_r, y_i;
    logic signed [TW-1:0] w_r, w_i;

    int     tests = 0;
    int     fails = 0;
    int     accepted = 0;
    longint cyc = 0;
    bit     rdone;
    exp_t   exp_q[$];
    beat_t  rb;

    radix2_bfly_pipe #(.DW(DW), .TW(TW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .scale(scale),
        .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i), .w_r(w_r), .w_i(w_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_r(x_r), .x_i(x_i), .y_r(y_r), .y_i(y_i), .sat(sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    function automatic void chk(string name, longint act, longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    // Reference: butterfly equations on plain integers, then scale and fit to DW bits.
    function automatic exp_t model(beat_t b);
        exp_t   e;
        longint ar = b.a_r, ai = b.a_i, br = b.b_r, bi = b.b_i, wr = b.w_r, wi = b.w_i;
        longint opr, opi, pr, pim, m;
        longint r[4];
        longint half = longint'(1) <<< (TW-2);
        longint lim  = longint'(1) <<< (DW-1);
        opr = b.mode ? ar - br : br;
        opi = b.mode ? ai - bi : bi;
        pr  = (opr * wr - opi * wi + half) >>> (TW-1);
        pim = (opr * wi + opi * wr + half) >>> (TW-1);
        if (!b.mode) r = '{ar + pr, ai + pim, ar - pr, ai - pim};
        else         r = '{ar + br, ai + bi, pr, pim};
        e.sat = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (b.scale) r[k] = (r[k] + 1) >>> 1;
`ifdef BFLY_SAT_EN
            if (r[k] >= lim) begin
                r[k] = lim - 1;
                e.sat = 1'b1;
            end else if (r[k] < -lim) begin
                r[k] = -lim;
                e.sat = 1'b1;
            end
`else
            m = (r[k] + lim) % (2 * lim);
            if (m < 0) m += 2 * lim;
            r[k] = m - lim;
`endif
        end
        e.x_r = r[0]; e.x_i = r[1]; e.y_r = r[2]; e.y_i = r[3];
        e.lat = 1'b0;
        e.acc = 0;
        return e;
    endfunction

    function automatic logic signed [DW-1:0] rnd_d();
        logic signed [DW-1:0] t;
        case ($urandom_range(0, 5))
            0: t = {1'b0, {(DW-1){1'b1}}};
            1: t = {1'b1, {(DW-1){1'b0}}};
            2: begin t = DW'($urandom_range(0, 31)); t = t - 16; end
            default: t = DW'($urandom);
        endcase
        return t;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        b.a_r = rnd_d(); b.a_i = rnd_d(); b.b_r = rnd_d(); b.b_i = rnd_d();
        b.w_r = TW'($urandom); b.w_i = TW'($urandom);
        b.mode = 1'($urandom); b.scale = 1'($urandom);
        return b;
    endfunction

    function automatic beat_t mk(bit md, bit sc, int ar, int ai, int br, int bi, int wr, int wi);
        beat_t b;
        b.mode = md; b.scale = sc;
        b.a_r = DW'(ar); b.a_i = DW'(ai); b.b_r = DW'(br); b.b_i = DW'(bi);
        b.w_r = TW'(wr); b.w_i = TW'(wi);
        return b;
    endfunction

    function automatic exp_t mk_e(int xr, int xi, int yr, int yi, bit s);
        exp_t e;
        e.x_r = xr; e.x_i = xi; e.y_r = yr; e.y_i = yi; e.sat = s;
        e.lat = 1'b1; e.acc = 0;
        return e;
    endfunction

    task automatic drive(input beat_t b);
        a_r = b.a_r; a_i = b.a_i; b_r = b.b_r; b_i = b.b_i;
        w_r = b.w_r; w_i = b.w_i; mode = b.mode; scale = b.scale;
        in_valid = 1'b1;
    endtask

    // Presents a beat and pushes its expectation at the negedge before the accepting edge.
    task automatic send(input beat_t b, input exp_t e);
        bit done = 1'b0;
        @(posedge clk); #1;
        drive(b);
        for (int w = 0; w < 64 && !done; w++) begin
            @(negedge clk);
            if (in_ready && rst) begin
                e.acc = cyc;
                exp_q.push_back(e);
                accepted++;
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL in_ready_timeout: in_ready=%0b, required 1", in_ready);
            in_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; in_valid = 1'b0; end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
        chk("drain_left", longint'(exp_q.size()), 0);
    endtask

    task automatic monitor();
        exp_t e;
        bit   held = 1'b0;
        logic signed [DW-1:0] h[4];
        logic hs;
        forever begin
            @(negedge clk);
            if (rst && out_valid) begin
                if (held) begin
                    chk("hold_x_r", x_r, h[0]); chk("hold_x_i", x_i, h[1]);
                    chk("hold_y_r", y_r, h[2]); chk("hold_y_i", y_i, h[3]);
                    chk("hold_sat", sat, hs);
                end
                if (out_ready) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_beat: out_valid=1 x_r=%0d, required no beat", x_r);
                    end else begin
                        e = exp_q.pop_front();
                        chk("x_r", x_r, e.x_r); chk("x_i", x_i, e.x_i);
                        chk("y_r", y_r, e.y_r); chk("y_i", y_i, e.y_i);
                        chk("sat", sat, e.sat);
                        if (e.lat) chk("latency", cyc - e.acc, 4);
                    end
                end else begin
                    held = 1'b1;
                    h[0] = x_r; h[1] = x_i; h[2] = y_r; h[3] = y_i; hs = sat;
                end
            end else begin
                held = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0; scale = 1'b0;
        a_r = '0; a_i = '0; b_r = '0; b_i = '0; w_r = '0; w_i = '0;
        fork monitor(); join_none
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0); chk("rst_in_ready", in_ready, 1);
        chk("rst_x_r", x_r, 0); chk("rst_x_i", x_i, 0);
        chk("rst_y_r", y_r, 0); chk("rst_y_i", y_i, 0); chk("rst_sat", sat, 0);

        send(mk(0, 0, 100, 0, 64, 0, 0, -128), mk_e(100, -64, 100, 64, 0)); idle(1); drain();
        send(mk(1, 0, 10, 20, 4, 6, 0, -128), mk_e(14, 26, 14, -6, 0)); idle(1); drain();
`ifdef BFLY_SAT_EN
        send(mk(0, 0, 32767, 0, 32767, 0, 127, 0), mk_e(32767, 0, 256, 0, 1)); idle(1); drain();
`else
        send(mk(0, 0, 32767, 0, 32767, 0, 127, 0), mk_e(-258, 0, 256, 0, 0)); idle(1); drain();
`endif
        send(mk(0, 1, 101, 0, 0, 0, 127, 0), mk_e(51, 0, 51, 0, 0)); idle(1); drain();

        // Backpressure: six back-to-back beats against a blocked output.
        @(posedge clk); #1 out_ready = 1'b0;
        accepted = 0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin rb = rand_beat(); send(rb, model(rb)); end
                idle(1);
            end
            begin
                repeat (10) @(posedge clk);
                @(negedge clk);
                chk("bp_accepted", accepted, 4);
                chk("bp_in_ready", in_ready, 0);
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three beats in flight and a beat offered during the reset cycle.
        for (int k = 0; k < 3; k++) begin rb = rand_beat(); send(rb, model(rb)); end
        @(posedge clk); #1;
        chk("rst_inflight", longint'(exp_q.size()), 3);
        rb = rand_beat(); drive(rb); rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", out_valid, 0); chk("mid_rst_x_r", x_r, 0);
        chk("mid_rst_x_i", x_i, 0); chk("mid_rst_y_r", y_r, 0);
        chk("mid_rst_y_i", y_i, 0); chk("mid_rst_sat", sat, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        exp_q.delete();
        rst = 1'b1; in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1 chk("post_rst_out_valid", out_valid, 0);

        // Random beats with random gaps and random output stalls.
        rdone = 1'b0;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    rb = rand_beat();
                    send(rb, model(rb));
                    if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
                end
                idle(1);
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/radix2_bfly_pipe.md
RADIX2_BFLY_PIPE -- requirements
Module: radix2_bfly_pipe

Interface
REQ-001 SHALL have parameter DW, default 41, signed data component width.
REQ-002 SHALL have parameter TW, default 8, signed twiddle component width; twiddle unity = 2^(TW-1).
REQ-003 SHALL have ports clk input 1, rising-edge clock, and rst input 1, synchronous active-low reset.
REQ-004 SHALL have in_valid input 1 and in_ready output 1, the input handshake.
REQ-005 SHALL have mode input 1: 0 = DIT, 1 = DIF, and scale input 1: halve results; both sampled per beat.
REQ-006 SHALL have a_r, a_i, b_r, b_i inputs DW each, signed operands a and b.
REQ-007 SHALL have w_r, w_i inputs TW each, signed twiddle.
REQ-008 SHALL have out_valid output 1 and out_ready input 1, the output handshake.
REQ-009 SHALL have x_r, x_i, y_r, y_i outputs DW each, signed results X and Y.
REQ-010 SHALL have sat output 1, high with a beat if any of its four result components saturated.

Function
REQ-011 SHALL accept a beat when in_valid && in_ready, and present a beat when out_valid && out_ready.
REQ-012 SHALL define the pipeline advance as adv = !out_valid || out_ready, with in_ready = adv, so the whole pipe stalls as one unit.
REQ-013 SHALL register four stages (S1 capture, S2 pre-add, S3 complex multiply, S4 combine/scale/saturate to outputs), giving exactly 4 advancing cycles from accept to out_valid.
REQ-014 SHALL carry a per-stage valid bit, clear it when the stage advances without a new beat, and hold all stage data while adv=0.
REQ-015 SHALL compute the twiddle product as P = b*w (DIT) or P = (a-b)*w (DIF), each component rounded as (p + 2^(TW-2)) >>> (TW-1).
REQ-016 SHALL produce, in DIT mode, X = a + P and Y = a - P.
REQ-017 SHALL produce, in DIF mode, X = a + b and Y = P.
REQ-018 SHALL form all intermediates at DW+TW+2 bits, with no intermediate overflow.
REQ-019 SHALL, when scale=1, replace each result r by (r + 1) >>> 1 before the saturate/wrap step.
REQ-020 SHALL preserve beat order and never drop or duplicate a beat under any out_ready pattern.
REQ-021 SHALL keep outputs and sat stable while out_valid=1 and out_ready=0.

Reset
REQ-022 SHALL, with rst=0 at a clk edge, clear every stage valid, out_valid, sat and x/y outputs to 0, and hold in_ready=1 after reset.
REQ-023 SHALL discard in-flight beats on reset mid-stream, and accept no beat on a reset cycle.

Configuration
REQ-024 SHALL, with macro BFLY_SAT_EN defined, clamp each result component to [-2^(DW-1), 2^(DW-1)-1] and raise sat for that beat.
REQ-025 SHALL, without BFLY_SAT_EN, wrap each result modulo 2^DW and tie sat to 0.

Structure
REQ-026 SHALL place the mode encoding constants (MODE_DIT=0, MODE_DIF=1) in shared package bfly_pkg.
REQ-027 SHALL implement the rounded complex multiply as sub-module bfly_cmul (parameters DW+1, TW), instantiated once between S2 and S3, with operands muxed by mode.

Verification (DW=16, TW=8)
REQ-028 SHALL verify DIT: a=(100,0), b=(64,0), w=(0,-128) -> X=(100,-64), Y=(100,64), out_valid 4 cycles after accept.
REQ-029 SHALL verify DIF: a=(10,20), b=(4,6), w=(0,-128) -> X=(14,26), Y=(14,-6).
REQ-030 SHALL verify DIT overflow: a=(32767,0), b=(32767,0), w=(127,0) -> X_r=32767 with sat=1 (BFLY_SAT_EN), or X_r=-258 with sat=0 (no macro); Y_r=256 in both builds.
REQ-031 SHALL verify scale: DIT a=(101,0), b=(0,0), w=(127,0), scale=1 -> X=(51,0), Y=(51,0).
REQ-032 SHALL verify backpressure: 6 back-to-back beats with out_ready=0 for 10 cycles -> exactly 4 accepted and in_ready=0 until out_ready=1, then all 6 emerge in order with unchanged values.
REQ-033 SHALL verify reset: rst=0 for one cycle with 3 beats in flight -> out_valid=0 and outputs 0 on the next cycle, and no stale beat appears afterwards.
